nes_mem_sched: RTL and testbench
================================

Name: nes_mem_sched

Overview:
- Sequences all SDRAM accesses for the NES core and replaces the ad-hoc loader-write glue at top level.
- Owns the 4-phase NES clock-enable counter.
- Buffers game_loader byte writes in a small FIFO and drains them one per NES slot.
- Hands the SDRAM port over to the NES CPU/PPU once loading has completed and drained; it also generates the NES reset.

Parameters:
- FIFO_DEPTH, 4, loader write FIFO entries; power of two, minimum 2.
- ADDR_W, 22, NES/loader byte address width.
- MEM_ADDR_W, 25, SDRAM controller address width; upper bits are zero-filled.

Ports:
- clock  in  1  system clock (21 MHz domain).
- reset_n  in  1  asynchronous active-low reset.
- load_done  in  1  game_loader completion flag, level.
- ldr_wr  in  1  one-cycle loader write strobe.
- ldr_addr  in  ADDR_W  loader write address.
- ldr_data  in  8  loader write byte.
- ldr_full  out  1  FIFO full.
- ovf  out  1  sticky: a loader write was dropped.
- nes_addr  in  ADDR_W  NES memory address.
- nes_rd_cpu  in  1  CPU read request.
- nes_rd_ppu  in  1  PPU read request.
- nes_wr  in  1  NES write request.
- nes_dout  in  8  NES write data.
- run_nes  out  1  NES clock enable.
- clkref  out  1  SDRAM controller phase reference.
- nes_reset  out  1  NES core reset, active high.
- mem_addr  out  MEM_ADDR_W  SDRAM controller address.
- mem_we  out  1  SDRAM write request.
- mem_din  out  8  SDRAM write byte.
- mem_oe_a  out  1  SDRAM read port A (CPU).
- mem_oe_b  out  1  SDRAM read port B (PPU).
- sd_drive  out  1  SDRAM data-bus output enable; equals mem_we.

Behaviour:
Phase counter
- phase[1:0] resets to 0 and increments every clock, wrapping 3 -> 0.
- run_nes = (phase==3); clkref = phase[1]. Both are combinational from phase.

Mode FSM (states LOAD, DRAIN, RUN; reset -> LOAD)
- LOAD: when load_done=1 at a phase==3 edge -> DRAIN.
- DRAIN: when the FIFO is empty and there is no loader write in flight at a phase==3 edge -> RUN. If load_done drops -> LOAD.
- RUN: if load_done drops (reload) -> LOAD at the next phase==3 edge.
- nes_reset = 1 in LOAD and DRAIN, 0 in RUN. The register resets to 1.
- run_nes keeps toggling during nes_reset so the NES reset can complete.

FIFO
- Push on ldr_wr when not full.
- Pop only at phase==3, in LOAD or DRAIN, when not empty.
- Simultaneous push and pop when full is accepted; the count is unchanged.
- Push when full without a pop: entry dropped, ovf set. ovf clears only on reset.
- ldr_full = (count==FIFO_DEPTH).
- ldr_wr is accepted in every state; in RUN it is still buffered but not drained until the next LOAD.

Loader write slot (LOAD/DRAIN)
- A pop registers the entry into the write-slot registers wa/wd and sets wv=1 at the phase==3 edge.
- wv is held for the following 4 cycles (phases 0..3).
- At the next phase==3 edge, wv takes the value of the next pop (1 if the FIFO has data, else 0).
- Outputs: mem_addr = {0, wa}, mem_din = wd, mem_we = wv, mem_oe_a = mem_oe_b = 0.
- Write latency: a push into an empty FIFO reaches mem_we at the first phase==3 edge after it, within 1 to 4 cycles.

RUN
- Combinational passthrough: mem_addr = {0, nes_addr}, mem_din = nes_dout, mem_we = nes_wr, mem_oe_a = nes_rd_cpu, mem_oe_b = nes_rd_ppu.
- sd_drive = mem_we in all states.

Reset values
- phase = 0, state LOAD, FIFO empty, wv = 0, ovf = 0, nes_reset = 1, mem_we = 0.
- The passthrough outputs are 0 while wv = 0.
- Reset asserted mid-load flushes the FIFO and the write slot immediately (asynchronous).

Decomposition:
- Package nes_mem_pkg holds: mode enum (LOAD, DRAIN, RUN), PHASE_RUN = 2'd3, and the loader entry struct {addr[ADDR_W], data[8]}.
- One sub-module, nes_ldr_fifo: a synchronous FIFO with count, full/empty, and push/pop on the same clock and the same asynchronous active-low reset.

Test Plan:
1. Reset, idle 8 cycles -> run_nes pulses at cycles 3 and 7; clkref is high in phases 2 and 3; nes_reset = 1; mem_we = 0.
2. Single ldr_wr addr=0x000010, data=0xA5 at phase 0 -> at the next phase==3 edge mem_addr = 0x0000010, mem_din = 0xA5, mem_we = 1 for exactly 4 cycles, then 0.
3. 6 back-to-back ldr_wr with FIFO_DEPTH=4, no drain in between -> ldr_full asserts after 4 accepted writes; ovf = 1; exactly the accepted entries appear on mem_we in order, 4 cycles each; the dropped writes never appear.
4. load_done rises while 3 entries are queued -> state stays DRAIN until all 3 entries are written; nes_reset falls at the phase==3 edge after the last write slot; then nes_rd_cpu = 1 with nes_addr = 0x1234 gives mem_oe_a = 1 and mem_addr = 0x0001234.
5. In RUN, drop load_done -> LOAD at the next phase==3 edge; nes_reset = 1; nes_wr is ignored (mem_we = 0); mem_oe_a and mem_oe_b are forced to 0.
6. Assert reset_n low mid-drain with 2 entries queued -> all outputs reach reset values asynchronously; after release the FIFO is empty and no stale write is issued.

Source files
------------

// File: rtl/nes_mem_pkg.sv
// Shared types for the NES memory scheduler: operating modes, the NES run phase
// and the buffered loader write entry.
package nes_mem_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        RUN   = 2'd2
    } mode_e;

    localparam logic [1:0] PHASE_RUN = 2'd3;

    // Loader entries carry a fixed-width address; ADDR_W must not exceed it.
    localparam int LDR_ADDR_W = 22;

    typedef struct packed {
        logic [LDR_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } ldr_entry_t;

endpackage

// File: rtl/nes_ldr_fifo.sv
// Small synchronous FIFO for loader writes. A push while full is accepted only
// when a pop happens on the same edge.
module nes_ldr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone define validity.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nes_mem_sched.sv
// SDRAM access scheduler for the NES core: phase counter, loader write buffering
// and drain, NES reset generation and hand-over of the SDRAM port to the NES.
module nes_mem_sched
    import nes_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 22,
    parameter int MEM_ADDR_W = 25
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_done,
    input  logic                  ldr_wr,
    input  logic [ADDR_W-1:0]     ldr_addr,
    input  logic [7:0]            ldr_data,
    output logic                  ldr_full,
    output logic                  ovf,
    input  logic [ADDR_W-1:0]     nes_addr,
    input  logic                  nes_rd_cpu,
    input  logic                  nes_rd_ppu,
    input  logic                  nes_wr,
    input  logic [7:0]            nes_dout,
    output logic                  run_nes,
    output logic                  clkref,
    output logic                  nes_reset,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_din,
    output logic                  mem_oe_a,
    output logic                  mem_oe_b,
    output logic                  sd_drive
);

    logic [1:0]        phase;
    logic              phase_run;
    mode_e             state;
    mode_e             state_nx;

    ldr_entry_t        push_entry;
    ldr_entry_t        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    logic              wv;
    logic [ADDR_W-1:0] wa;
    logic [7:0]        wd;

    assign phase_run = (phase == PHASE_RUN);
    assign run_nes   = phase_run;
    assign clkref    = phase[1];

    assign push_entry = '{addr: LDR_ADDR_W'(ldr_addr), data: ldr_data};
    assign fifo_pop   = phase_run && (state != RUN) && !fifo_empty;
    assign ldr_full   = fifo_full;

    nes_ldr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(ldr_entry_t))
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (ldr_wr),
        .wdata   (push_entry),
        .pop     (fifo_pop),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // NOTE: defaults first so no path through the block leaves a latch.
    always_comb begin
        state_nx = state;
        if (phase_run) begin
            case (state)
                LOAD:    if (load_done) state_nx = DRAIN;
                DRAIN: begin
                    // A write arriving on this edge must still be drained.
                    if (!load_done)                 state_nx = LOAD;
                    else if (fifo_empty && !ldr_wr) state_nx = RUN;
                end
                RUN:     if (!load_done) state_nx = LOAD;
                default: state_nx = LOAD;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= '0;
            state     <= LOAD;
            nes_reset <= 1'b1;
            ovf       <= 1'b0;
            wv        <= 1'b0;
            wa        <= '0;
            wd        <= '0;
        end else begin
            phase     <= phase + 2'd1;
            state     <= state_nx;
            nes_reset <= (state_nx != RUN);
            if (ldr_wr && fifo_full && !fifo_pop) ovf <= 1'b1;
            // The write slot spans exactly one NES cycle, refreshed each run edge.
            if (phase_run) begin
                wv <= fifo_pop;
                if (fifo_pop) begin
                    wa <= ADDR_W'(fifo_head.addr);
                    wd <= fifo_head.data;
                end
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        mem_oe_a = 1'b0;
        mem_oe_b = 1'b0;
        if (state == RUN) begin
            mem_addr = MEM_ADDR_W'(nes_addr);
            mem_din  = nes_dout;
            mem_we   = nes_wr;
            mem_oe_a = nes_rd_cpu;
            mem_oe_b = nes_rd_ppu;
        end else if (wv) begin
            mem_addr = MEM_ADDR_W'(wa);
            mem_din  = wd;
            mem_we   = 1'b1;
        end
    end

    assign sd_drive = mem_we;

endmodule

// File: tb/tb_nes_mem_sched.sv
// Self-checking bench for nes_mem_sched: directed loader/NES stimulus with a
// scoreboard of expected SDRAM write slots checked by an independent monitor.
module tb_nes_mem_sched;

    localparam int ADDR_W     = 22;
    localparam int MEM_ADDR_W = 25;
    localparam int FIFO_DEPTH = 4;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic                  load_done;
    logic                  ldr_wr;
    logic [ADDR_W-1:0]     ldr_addr;
    logic [7:0]            ldr_data;
    logic                  ldr_full;
    logic                  ovf;
    logic [ADDR_W-1:0]     nes_addr;
    logic                  nes_rd_cpu;
    logic                  nes_rd_ppu;
    logic                  nes_wr;
    logic [7:0]            nes_dout;
    logic                  run_nes;
    logic                  clkref;
    logic                  nes_reset;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_we;
    logic [7:0]            mem_din;
    logic                  mem_oe_a;
    logic                  mem_oe_b;
    logic                  sd_drive;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         total = 0;
    int         bad   = 0;
    logic [1:0] tb_phase;
    bit         in_run  = 1'b0;
    bit         in_slot = 1'b0;

    nes_mem_sched #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .MEM_ADDR_W (MEM_ADDR_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_done  (load_done),
        .ldr_wr     (ldr_wr),
        .ldr_addr   (ldr_addr),
        .ldr_data   (ldr_data),
        .ldr_full   (ldr_full),
        .ovf        (ovf),
        .nes_addr   (nes_addr),
        .nes_rd_cpu (nes_rd_cpu),
        .nes_rd_ppu (nes_rd_ppu),
        .nes_wr     (nes_wr),
        .nes_dout   (nes_dout),
        .run_nes    (run_nes),
        .clkref     (clkref),
        .nes_reset  (nes_reset),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_din    (mem_din),
        .mem_oe_a   (mem_oe_a),
        .mem_oe_b   (mem_oe_b),
        .sd_drive   (sd_drive)
    );

    initial forever #5 clock = ~clock;

    // Bench-side phase model: free-running counter cleared by reset.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) tb_phase <= 2'd0;
        else          tb_phase <= tb_phase + 2'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    // Monitor: each loader write slot starts at phase 0 and must hold for 4 cycles.
    initial forever begin
        @(negedge clock);
        if (!reset_n || in_run) begin
            in_slot = 1'b0;
        end else if (tb_phase == 2'd0) begin
            in_slot = mem_we;
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check_bit("unexpected_write", mem_we, 1'b0);
                    in_slot = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    check("slot_addr", 32'(mem_addr), 32'(cur.addr));
                    check("slot_data", 32'(mem_din), 32'(cur.data));
                    check_bit("slot_drive", sd_drive, 1'b1);
                end
            end
        end else if (in_slot) begin
            check_bit("slot_hold_we", mem_we, 1'b1);
            check("slot_hold_addr", 32'(mem_addr), 32'(cur.addr));
            check("slot_hold_data", 32'(mem_din), 32'(cur.data));
        end else begin
            check_bit("idle_we", mem_we, 1'b0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_phase(input logic [1:0] p);
        int n = 0;
        do begin
            step();
            n++;
        end while (tb_phase != p && n < 8);
    endtask

    task automatic ldr_push(input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit accept);
        ldr_wr   = 1'b1;
        ldr_addr = a;
        ldr_data = d;
        if (accept) exp_q.push_back('{addr: a, data: d});
    endtask

    // Waits until every expected slot has been seen and mem_we has dropped.
    task automatic wait_drain(input int budget, input bit chk_reset);
        int n = 0;
        while ((exp_q.size() != 0 || mem_we) && n < budget) begin
            @(negedge clock);
            n++;
            if (chk_reset && (exp_q.size() != 0 || mem_we))
                check_bit("reset_during_drain", nes_reset, 1'b1);
        end
        check_bit("drain_in_budget", n < budget, 1'b1);
    endtask

    initial begin
        reset_n    = 1'b0;
        load_done  = 1'b0;
        ldr_wr     = 1'b0;
        ldr_addr   = '0;
        ldr_data   = '0;
        nes_addr   = '0;
        nes_rd_cpu = 1'b0;
        nes_rd_ppu = 1'b0;
        nes_wr     = 1'b0;
        nes_dout   = '0;

        // Reset state
        #12;
        check_bit("rst_nes_reset", nes_reset, 1'b1);
        check_bit("rst_mem_we", mem_we, 1'b0);
        check_bit("rst_ovf", ovf, 1'b0);
        check_bit("rst_full", ldr_full, 1'b0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        step();
        reset_n = 1'b1;

        // 1: idle phase pattern
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check_bit("run_nes_pattern", run_nes, (i % 4) == 3);
            check_bit("clkref_pattern", clkref, (i % 4) >= 2);
            check_bit("idle_nes_reset", nes_reset, 1'b1);
            check_bit("idle_oe_a", mem_oe_a, 1'b0);
        end

        // 2: single loader write issued at phase 0
        wait_phase(2'd0);
        ldr_push(22'h000010, 8'hA5, 1'b1);
        step();
        ldr_wr = 1'b0;
        wait_drain(32, 1'b0);

        // 3: six back-to-back writes starting at phase 3; fifth rides a pop, sixth drops
        wait_phase(2'd3);
        for (int k = 0; k < 6; k++) begin
            ldr_push(22'(32'h100 + k), 8'(8'h10 + k), k < 5);
            @(negedge clock);
            check_bit("full_before_write", ldr_full, k >= 4);
            check_bit("ovf_before_write", ovf, 1'b0);
            step();
        end
        ldr_wr = 1'b0;
        @(negedge clock);
        check_bit("full_after_burst", ldr_full, 1'b1);
        check_bit("ovf_after_drop", ovf, 1'b1);
        wait_drain(60, 1'b0);
        check_bit("drained_not_full", ldr_full, 1'b0);

        // 4: load_done rises with 3 entries queued, then hand-over to the NES
        wait_phase(2'd3);
        ldr_push(22'h2AAAAA, 8'h11, 1'b1);
        step();
        ldr_push(22'h155555, 8'h22, 1'b1);
        step();
        ldr_push(22'h000333, 8'h33, 1'b1);
        step();
        ldr_wr    = 1'b0;
        load_done = 1'b1;
        wait_drain(40, 1'b1);
        check_bit("run_after_drain", nes_reset, 1'b0);
        in_run = 1'b1;
        step();
        nes_addr   = 22'h001234;
        nes_rd_cpu = 1'b1;
        nes_wr     = 1'b1;
        nes_dout   = 8'h5A;
        @(negedge clock);
        check_bit("pass_oe_a", mem_oe_a, 1'b1);
        check_bit("pass_oe_b", mem_oe_b, 1'b0);
        check("pass_addr", 32'(mem_addr), 32'h0001234);
        check_bit("pass_we", mem_we, 1'b1);
        check_bit("pass_drive", sd_drive, 1'b1);
        check("pass_din", 32'(mem_din), 32'h5A);

        // 5: reload request returns to LOAD at the next run edge
        wait_phase(2'd0);
        load_done  = 1'b0;
        nes_rd_ppu = 1'b1;
        nes_addr   = 22'h002222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_bit("run_until_edge", nes_reset, 1'b0);
            check_bit("pass_oe_b", mem_oe_b, 1'b1);
            if (i < 3) step();
        end
        step();
        in_run = 1'b0;
        @(negedge clock);
        check_bit("reload_nes_reset", nes_reset, 1'b1);
        check_bit("reload_we_ignored", mem_we, 1'b0);
        check_bit("reload_oe_a", mem_oe_a, 1'b0);
        check_bit("reload_oe_b", mem_oe_b, 1'b0);
        check_bit("reload_drive", sd_drive, 1'b0);
        check("reload_addr", 32'(mem_addr), 32'h0);
        check_bit("ovf_sticky", ovf, 1'b1);
        step();
        nes_rd_cpu = 1'b0;
        nes_rd_ppu = 1'b0;
        nes_wr     = 1'b0;

        // 6: asynchronous reset mid-drain with 2 entries still queued
        wait_phase(2'd3);
        ldr_push(22'h000A01, 8'hC1, 1'b1);
        step();
        ldr_push(22'h000A02, 8'hC2, 1'b0);
        step();
        ldr_push(22'h000A03, 8'hC3, 1'b0);
        step();
        ldr_wr    = 1'b0;
        load_done = 1'b1;
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        check_bit("async_we", mem_we, 1'b0);
        check_bit("async_drive", sd_drive, 1'b0);
        check_bit("async_nes_reset", nes_reset, 1'b1);
        check_bit("async_ovf", ovf, 1'b0);
        check_bit("async_clkref", clkref, 1'b0);
        check_bit("async_run_nes", run_nes, 1'b0);
        check("async_addr", 32'(mem_addr), 32'h0);
        check("async_din", 32'(mem_din), 32'h0);
        load_done = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check_bit("no_stale_write", mem_we, 1'b0);
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
